// File: rtl/led_driver_pkg.sv
// Shared definitions for the MAX7219 matrix driver: FSM states, frame size and the
// fixed init/row word table sent on every frame.
package led_driver_pkg;

   typedef enum logic [2:0] {IDLE, LOAD, SHIFT, LATCH, GAP} state_t;

   localparam int unsigned N_WORDS = 13;
   localparam int unsigned IDX_W   = 4;

   // Five register-init words followed by the eight row patterns.
   function automatic logic [15:0] frame_word(input logic [IDX_W-1:0] idx);
      case (idx)
         4'd0:    return 16'h0900;
         4'd1:    return 16'h0A08;
         4'd2:    return 16'h0B07;
         4'd3:    return 16'h0C01;
         4'd4:    return 16'h0F00;
         4'd5:    return 16'h013C;
         4'd6:    return 16'h0242;
         4'd7:    return 16'h03A5;
         4'd8:    return 16'h0481;
         4'd9:    return 16'h05A5;
         4'd10:   return 16'h0699;
         4'd11:   return 16'h0742;
         4'd12:   return 16'h083C;
         default: return '0;
      endcase
   endfunction

endpackage

// File: rtl/spi_tx_word.sv
// 16-bit MSB-first SPI serialiser, CPOL=0: SCK half-period is CLK_DIV clocks,
// MOSI updates on the falling toggle, done pulses on the final falling toggle.
module spi_tx_word #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] data,
   output logic        done,
   output logic        sck,
   output logic        mosi
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic             busy;
   logic [DIV_W-1:0] div;
   logic [3:0]       bit_cnt;
   logic [14:0]      shreg;
   logic             tick;

   assign tick = busy && (div == DIV_LAST);
   assign done = tick && sck && (bit_cnt == 4'd15);

   // Bit 15 goes straight to MOSI on load, so only the remaining 15 bits are held.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy    <= 1'b0;
         div     <= '0;
         bit_cnt <= '0;
         shreg   <= '0;
         sck     <= 1'b0;
         mosi    <= 1'b0;
      end else if (load) begin
         busy    <= 1'b1;
         div     <= '0;
         bit_cnt <= '0;
         shreg   <= data[14:0];
         sck     <= 1'b0;
         mosi    <= data[15];
      end else if (busy) begin
         if (tick) begin
            div <= '0;
            sck <= ~sck;
            if (sck) begin
               if (bit_cnt == 4'd15) begin
                  busy <= 1'b0;
               end else begin
                  mosi    <= shreg[14];
                  shreg   <= {shreg[13:0], 1'b0};
                  bit_cnt <= bit_cnt + 4'd1;
               end
            end
         end else begin
            div <= div + 1'b1;
         end
      end
   end

endmodule

// File: rtl/led_driver.sv
// Frame sequencer for a MAX7219-style 8x8 matrix: on a start edge sends 13 words
// (5 init + 8 rows) with CS framing, then reports ready again.
module led_driver
   import led_driver_pkg::*;
#(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic in_clk,
   input  logic in_rst,
   input  logic in_IR_START,
   output logic out_IR_READY,
   output logic out_LED_CLK,
   output logic out_MOSI,
   output logic out_CS
);

   localparam int unsigned DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);

   state_t           state, state_nxt;
   logic [IDX_W-1:0] word_idx, idx_nxt;
   logic [DIV_W-1:0] cnt, cnt_nxt;
   logic             cs_q, cs_nxt;
   logic             ready_q, ready_nxt;
   logic             start_prev;
   logic             start_pulse;
   logic             tx_load, tx_done, tx_sck, tx_mosi;

   assign start_pulse = in_IR_START & ~start_prev;

   spi_tx_word #(.CLK_DIV(CLK_DIV)) u_tx (
      .clk   (in_clk),
      .rst_n (in_rst),
      .load  (tx_load),
      .data  (frame_word(word_idx)),
      .done  (tx_done),
      .sck   (tx_sck),
      .mosi  (tx_mosi)
   );

   always_ff @(posedge in_clk or negedge in_rst) begin
      if (!in_rst) begin
         state      <= IDLE;
         word_idx   <= '0;
         cnt        <= '0;
         cs_q       <= 1'b1;
         ready_q    <= 1'b1;
         start_prev <= 1'b0;
      end else begin
         state      <= state_nxt;
         word_idx   <= idx_nxt;
         cnt        <= cnt_nxt;
         cs_q       <= cs_nxt;
         ready_q    <= ready_nxt;
         start_prev <= in_IR_START;
      end
   end

   // CS drops on entry to LOAD so the inter-word high time is exactly the GAP length.
   always_comb begin
      state_nxt = state;
      idx_nxt   = word_idx;
      cnt_nxt   = cnt;
      cs_nxt    = cs_q;
      ready_nxt = ready_q;
      tx_load   = 1'b0;
      case (state)
         IDLE: begin
            if (start_pulse) begin
               state_nxt = LOAD;
               idx_nxt   = '0;
               ready_nxt = 1'b0;
               cs_nxt    = 1'b0;
            end
         end
         LOAD: begin
            tx_load   = 1'b1;
            cnt_nxt   = '0;
            state_nxt = SHIFT;
         end
         SHIFT: begin
            if (tx_done) begin
               cnt_nxt   = '0;
               state_nxt = LATCH;
            end
         end
         LATCH: begin
            if (cnt == DIV_LAST) begin
               cnt_nxt   = '0;
               cs_nxt    = 1'b1;
               state_nxt = GAP;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == DIV_LAST) begin
               cnt_nxt = '0;
               if (word_idx == LAST_IDX) begin
                  state_nxt = IDLE;
                  ready_nxt = 1'b1;
               end else begin
                  idx_nxt   = word_idx + 1'b1;
                  cs_nxt    = 1'b0;
                  state_nxt = LOAD;
               end
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign out_IR_READY = ready_q;
   assign out_CS       = cs_q;
   assign out_LED_CLK  = tx_sck;
   assign out_MOSI     = tx_mosi & ~cs_q;

endmodule

// File: tb/tb_led_driver.sv
// Self-checking bench for led_driver: CLK_DIV=4 and CLK_DIV=1 instances, SPI word
// decoder feeding a scoreboard, timing monitors and a reset/start vector table.
module tb_led_driver;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [1:0] rst_n;
   logic [1:0] start;
   logic [1:0] ready_o, sck_o, mosi_o, cs_o;

   led_driver #(.CLK_DIV(4)) dut (
      .in_clk(clk), .in_rst(rst_n[0]), .in_IR_START(start[0]),
      .out_IR_READY(ready_o[0]), .out_LED_CLK(sck_o[0]), .out_MOSI(mosi_o[0]), .out_CS(cs_o[0])
   );

   led_driver #(.CLK_DIV(1)) dut1 (
      .in_clk(clk), .in_rst(rst_n[1]), .in_IR_START(start[1]),
      .out_IR_READY(ready_o[1]), .out_LED_CLK(sck_o[1]), .out_MOSI(mosi_o[1]), .out_CS(cs_o[1])
   );

   typedef struct {
      logic rst;
      logic start;
      logic cs;
      logic sck;
      logic mosi;
      logic ready;
   } vec_t;

   vec_t        tbl [5];
   logic [15:0] rom_exp [13];
   logic [15:0] q0 [$];
   logic [15:0] q1 [$];

   int checks = 0;
   int passed = 0;
   int cyc = 0;

   int          divk [2];
   logic [15:0] sh [2];
   logic [15:0] first_word [2];
   int bits [2], last_rise [2], mosi_chg [2], cs_rise [2], wc [2], windows [2];
   int fall_cyc [2], frame_len [2];
   int v_setup [2], v_hold [2], v_period [2], v_gap [2], v_idle [2], v_bits [2];
   logic [1:0] p_sck, p_cs, p_mosi, p_ready;

   always @(posedge clk) cyc++;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   task automatic push_frame(input int k);
      for (int i = 0; i < 13; i++) begin
         if (k == 0) q0.push_back(rom_exp[i]);
         else        q1.push_back(rom_exp[i]);
      end
   endtask

   task automatic pulse(input int k);
      @(posedge clk); #1 start[k] = 1'b1;
      @(posedge clk); #1 start[k] = 1'b0;
   endtask

   task automatic wait_ready(input int k, input int lim, input string name);
      int n = 0;
      while (ready_o[k] !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (ready_o[k] !== 1'b1) chk({name, "_timeout"}, 0, 1);
      @(negedge clk);
   endtask

   // SPI decoder and timing monitor, one lane per DUT instance.
   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         if (!rst_n[k]) begin
            bits[k] = 0;
            wc[k]   = 0;
         end else begin
            if (cs_o[k] && (mosi_o[k] || sck_o[k])) v_idle[k]++;
            if (p_ready[k] && !ready_o[k]) fall_cyc[k] = cyc;
            if (!p_ready[k] && ready_o[k]) frame_len[k] = cyc - fall_cyc[k];
            if (ready_o[k]) wc[k] = 0;
            if (p_cs[k] && !cs_o[k]) begin
               if (wc[k] > 0 && cyc - cs_rise[k] != divk[k]) v_gap[k]++;
               bits[k]     = 0;
               mosi_chg[k] = cyc;
            end
            if (!cs_o[k] && mosi_o[k] != p_mosi[k]) begin
               if (!p_cs[k] && (sck_o[k] || cyc - last_rise[k] < divk[k])) v_hold[k]++;
               mosi_chg[k] = cyc;
            end
            if (!p_sck[k] && sck_o[k]) begin
               if (cyc - mosi_chg[k] < divk[k]) v_setup[k]++;
               if (bits[k] > 0 && cyc - last_rise[k] != 2 * divk[k]) v_period[k]++;
               sh[k]        = {sh[k][14:0], mosi_o[k]};
               bits[k]      = bits[k] + 1;
               last_rise[k] = cyc;
            end
            if (!p_cs[k] && cs_o[k]) begin
               windows[k]++;
               cs_rise[k] = cyc;
               if (wc[k] == 0) first_word[k] = sh[k];
               wc[k]++;
               if (bits[k] != 16) begin
                  v_bits[k]++;
               end else if (k == 0) begin
                  chk("word_owed_0", (q0.size() > 0) ? 1 : 0, 1);
                  if (q0.size() > 0) chk("word_0", sh[k], q0.pop_front());
               end else begin
                  chk("word_owed_1", (q1.size() > 0) ? 1 : 0, 1);
                  if (q1.size() > 0) chk("word_1", sh[k], q1.pop_front());
               end
            end
         end
         p_sck[k]   = sck_o[k];
         p_cs[k]    = cs_o[k];
         p_mosi[k]  = mosi_o[k];
         p_ready[k] = ready_o[k];
      end
   end

   initial begin
      int bad;
      int base;
      rst_n = 2'b00;
      start = 2'b00;
      rom_exp = '{16'h0900, 16'h0A08, 16'h0B07, 16'h0C01, 16'h0F00, 16'h013C, 16'h0242,
                  16'h03A5, 16'h0481, 16'h05A5, 16'h0699, 16'h0742, 16'h083C};
      divk = '{4, 1};
      for (int k = 0; k < 2; k++) begin
         sh[k] = '0; first_word[k] = '0; bits[k] = 0; last_rise[k] = -1000;
         mosi_chg[k] = -1000; cs_rise[k] = -1000; wc[k] = 0; windows[k] = 0;
         fall_cyc[k] = 0; frame_len[k] = 0; v_setup[k] = 0; v_hold[k] = 0;
         v_period[k] = 0; v_gap[k] = 0; v_idle[k] = 0; v_bits[k] = 0;
      end
      p_sck = '0; p_cs = '1; p_mosi = '0; p_ready = '1;

      // reset held with no start for 1000 clocks
      bad = 0;
      repeat (1000) begin
         @(negedge clk);
         if (cs_o[0] !== 1'b1 || sck_o[0] !== 1'b0 || mosi_o[0] !== 1'b0 || ready_o[0] !== 1'b1) bad++;
      end
      chk("reset_hold_1000", bad, 0);

      // release with start already high: exactly one frame
      tbl[0] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[1] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[2] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
      push_frame(0);
      base = windows[0];
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         rst_n[0] = tbl[i].rst;
         start[0] = tbl[i].start;
         @(negedge clk);
         chk($sformatf("vec%0d_cs", i),    cs_o[0],    tbl[i].cs);
         chk($sformatf("vec%0d_sck", i),   sck_o[0],   tbl[i].sck);
         chk($sformatf("vec%0d_mosi", i),  mosi_o[0],  tbl[i].mosi);
         chk($sformatf("vec%0d_ready", i), ready_o[0], tbl[i].ready);
      end
      wait_ready(0, 3000, "held_frame");
      bad = 0;
      repeat (300) begin
         @(negedge clk);
         if (ready_o[0] !== 1'b1 || cs_o[0] !== 1'b1) bad++;
      end
      chk("held_no_retrigger", bad, 0);
      chk("held_windows", windows[0] - base, 13);
      chk("held_frame_len", frame_len[0], 1781);
      chk("held_queue_empty", q0.size(), 0);
      @(posedge clk); #1 start[0] = 1'b0;
      repeat (5) @(negedge clk);

      // two-clock start pulse, ready latency and frame length
      base = windows[0];
      push_frame(0);
      @(posedge clk); #1 start[0] = 1'b1;
      @(negedge clk); chk("ready_before_edge", ready_o[0], 1);
      @(posedge clk); #1;
      @(negedge clk); chk("ready_fell", ready_o[0], 0);
      @(posedge clk); #1 start[0] = 1'b0;
      wait_ready(0, 3000, "pulse_frame");
      chk("pulse_frame_len", frame_len[0], 1781);
      chk("pulse_windows", windows[0] - base, 13);
      chk("pulse_queue_empty", q0.size(), 0);

      // re-pulse mid-frame is ignored
      base = windows[0];
      push_frame(0);
      pulse(0);
      repeat (600) @(negedge clk);
      pulse(0);
      wait_ready(0, 3000, "repulse_frame");
      repeat (50) @(negedge clk);
      chk("repulse_windows", windows[0] - base, 13);
      chk("repulse_queue_empty", q0.size(), 0);

      // second frame after ready
      base = windows[0];
      push_frame(0);
      pulse(0);
      wait_ready(0, 3000, "second_frame");
      chk("second_windows", windows[0] - base, 13);
      chk("second_frame_len", frame_len[0], 1781);

      // reset during word 6, then a full frame from word 0
      push_frame(0);
      pulse(0);
      bad = 0;
      while (!(wc[0] >= 5 && !cs_o[0]) && bad < 3000) begin
         @(negedge clk);
         bad++;
      end
      chk("reach_word6", (wc[0] == 5 && !cs_o[0]) ? 1 : 0, 1);
      repeat (40) @(negedge clk);
      @(posedge clk); #1 rst_n[0] = 1'b0;
      #1;
      chk("abort_cs", cs_o[0], 1);
      chk("abort_sck", sck_o[0], 0);
      chk("abort_mosi", mosi_o[0], 0);
      chk("abort_ready", ready_o[0], 1);
      q0.delete();
      repeat (10) @(negedge clk);
      @(posedge clk); #1 rst_n[0] = 1'b1;
      base = windows[0];
      push_frame(0);
      pulse(0);
      wait_ready(0, 3000, "post_reset_frame");
      chk("post_reset_first_word", first_word[0], 16'h0900);
      chk("post_reset_windows", windows[0] - base, 13);
      chk("post_reset_queue_empty", q0.size(), 0);

      // CLK_DIV=1 instance
      @(posedge clk); #1 rst_n[1] = 1'b1;
      repeat (5) @(negedge clk);
      push_frame(1);
      pulse(1);
      wait_ready(1, 1000, "div1_frame");
      chk("div1_frame_len", frame_len[1], 455);
      chk("div1_windows", windows[1], 13);
      chk("div1_queue_empty", q1.size(), 0);

      for (int k = 0; k < 2; k++) begin
         chk($sformatf("mosi_setup_%0d", k),   v_setup[k], 0);
         chk($sformatf("mosi_hold_%0d", k),    v_hold[k], 0);
         chk($sformatf("sck_period_%0d", k),   v_period[k], 0);
         chk($sformatf("cs_gap_%0d", k),       v_gap[k], 0);
         chk($sformatf("idle_outputs_%0d", k), v_idle[k], 0);
         chk($sformatf("bits_per_word_%0d", k), v_bits[k], 0);
      end

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
